// File: rtl/serial_sub_if.sv
// serial_sub_if: operand/result handshake bundle for serial_sub; carries ovf when SERIAL_SUB_OVF_EN is defined
interface serial_sub_if #(parameter int WIDTH = 8);
  logic start_valid, start_ready, bin, res_valid, res_ready, borrow_out;
  logic [WIDTH-1:0] a, b, diff;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
  modport master (output start_valid, a, b, bin, res_ready, input start_ready, res_valid, diff, borrow_out, ovf);
  modport slave (input start_valid, a, b, bin, res_ready, output start_ready, res_valid, diff, borrow_out, ovf);
`else
  modport master (output start_valid, a, b, bin, res_ready, input start_ready, res_valid, diff, borrow_out);
  modport slave (input start_valid, a, b, bin, res_ready, output start_ready, res_valid, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_sub.sv
// serial_sub: bit-serial a - b - bin, one bit per clock LSB first; SERIAL_SUB_OVF_EN adds signed overflow output
module serial_sub #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  serial_sub_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, diff_q, r_n;
  logic [WIDTH-2:0] r_q;
  logic [CW-1:0] cnt_q;
  logic brw_q, bout_q, d, bo, last;
`ifdef SERIAL_SUB_OVF_EN
  logic am_q, bm_q, ovf_q;
  assign s.ovf = ovf_q;
`endif
  always_comb begin
    d = a_q[0] ^ b_q[0] ^ brw_q;
    bo = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    r_n = {d, r_q};
    last = cnt_q == CW'(WIDTH - 1);
    state_d = state_q == IDLE ? (s.start_valid ? RUN : IDLE) :
              state_q == RUN  ? (last ? DONE : RUN) :
              (s.res_ready ? IDLE : DONE);
  end
  assign s.start_ready = state_q == IDLE && !rst;
  assign s.res_valid = state_q == DONE;
  assign s.diff = diff_q;
  assign s.borrow_out = bout_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      diff_q <= '0;
      cnt_q <= '0;
      brw_q <= 1'b0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am_q <= 1'b0;
      bm_q <= 1'b0;
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && s.start_valid) begin
        a_q <= s.a;
        b_q <= s.b;
        brw_q <= s.bin;
        cnt_q <= '0;
`ifdef SERIAL_SUB_OVF_EN
        am_q <= s.a[WIDTH-1];
        bm_q <= s.b[WIDTH-1];
`endif
      end else if (state_q == RUN) begin
        a_q <= a_q >> 1;
        b_q <= b_q >> 1;
        r_q <= r_n[WIDTH-1:1];
        brw_q <= bo;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          diff_q <= r_n;
          bout_q <= bo;
`ifdef SERIAL_SUB_OVF_EN
          ovf_q <= (am_q ^ bm_q) & (d ^ am_q);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed checks of serial_sub against an arithmetic model; exhaustive sweep on a 4-bit instance
module tb_serial_sub;
  localparam int W = 8;
  typedef struct {logic [8:0] r; logic o; int acc;} op_t;
  logic clk = 0, rst = 1;
  int cyc = 0, tests = 0, fails = 0;
  bit chk_en = 0;
  op_t q[$];
  logic [7:0] last_d = 0;
  logic last_b = 0, last_o = 0;
  serial_sub_if #(.WIDTH(8)) s8();
  serial_sub_if #(.WIDTH(4)) s4();
  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .s(s8));
  serial_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .s(s4));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // model: one operation in flight, result due W edges after accept
  always @(negedge clk) if (chk_en) begin
    logic exp_rv, exp_sr;
    op_t o;
    exp_rv = q.size() > 0 && cyc >= q[0].acc + W;
    exp_sr = !rst && q.size() == 0;
    if (exp_rv) begin
      last_d = q[0].r[7:0];
      last_b = q[0].r[8];
      last_o = q[0].o;
    end
    chk("start_ready", s8.start_ready, exp_sr);
    chk("res_valid", s8.res_valid, exp_rv);
    chk("diff", s8.diff, last_d);
    chk("borrow_out", s8.borrow_out, last_b);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", s8.ovf, last_o);
`endif
    if (rst) begin
      q.delete();
      last_d = 0;
      last_b = 0;
      last_o = 0;
    end else begin
      if (exp_rv && s8.res_ready) void'(q.pop_front());
      if (exp_sr && s8.start_valid) begin
        o.r = {1'b0, s8.a} - {1'b0, s8.b} - {8'd0, s8.bin};
        o.o = (s8.a[7] != s8.b[7]) && (o.r[7] != s8.a[7]);
        o.acc = cyc + 1;
        q.push_back(o);
      end
    end
  end
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    bit ok = 0;
    s8.a = a;
    s8.b = b;
    s8.bin = bin;
    s8.start_valid = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (s8.start_ready) ok = 1;
    end
    chk("accept8", ok, 1);
    @(posedge clk);
    #1 s8.start_valid = 0;
  endtask
  task automatic wait_rv8();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (s8.res_valid) ok = 1;
    end
    chk("res_valid8_timeout", ok, 1);
  endtask
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] ed, input logic eb);
    issue8(a, b, bin);
    wait_rv8();
    chk("lit_diff", s8.diff, ed);
    chk("lit_borrow", s8.borrow_out, eb);
    @(posedge clk);
    #1;
  endtask
  task automatic op4(input int a, input int b, input int bin);
    bit ok = 0;
    s4.a = 4'(a);
    s4.b = 4'(b);
    s4.bin = 1'(bin);
    s4.start_valid = 1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (s4.start_ready) ok = 1;
    end
    @(posedge clk);
    #1 s4.start_valid = 0;
    for (int i = 0; i < 40 && ok && !s4.res_valid; i++) @(negedge clk);
    if (!(ok && s4.res_valid)) chk("exh4_timeout", 0, 1);
    else chk("exh4", {s4.borrow_out, s4.diff}, (a - b - bin) & 31);
    @(posedge clk);
    #1;
  endtask
  initial begin
    s8.start_valid = 0; s8.a = 0; s8.b = 0; s8.bin = 0; s8.res_ready = 1;
    s4.start_valid = 0; s4.a = 0; s4.b = 0; s4.bin = 0; s4.res_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ready", s8.start_ready, 0);
    chk("rst_res_valid", s8.res_valid, 0);
    chk("rst_diff", s8.diff, 0);
    chk("rst_borrow", s8.borrow_out, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_start_ready", s8.start_ready, 1);
    chk_en = 1;
    @(posedge clk);
    #1;
    run8(8'h5A, 8'h3C, 0, 8'h1E, 0);
    run8(8'h00, 8'h01, 0, 8'hFF, 1);
    run8(8'h10, 8'h10, 1, 8'hFF, 1);
    run8(8'h00, 8'h00, 1, 8'hFF, 1);
    run8(8'hFF, 8'h00, 0, 8'hFF, 0);
    // backpressure: result held while new operands wait
    s8.res_ready = 0;
    issue8(8'h33, 8'h11, 0);
    s8.a = 8'h44; s8.b = 8'h05; s8.bin = 0; s8.start_valid = 1;
    wait_rv8();
    for (int i = 0; i < 5; i++) begin
      chk("bp_start_ready", s8.start_ready, 0);
      chk("bp_diff", s8.diff, 8'h22);
      @(negedge clk);
    end
    @(posedge clk);
    #1 s8.res_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_after_U", s8.start_ready, 1);
    @(posedge clk);
    #1 s8.start_valid = 0;
    wait_rv8();
    chk("bp_new_diff", s8.diff, 8'h3F);
    @(posedge clk);
    #1;
    // reset during the 4th RUN cycle
    issue8(8'h12, 8'h34, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("abort_start_ready", s8.start_ready, 1);
    chk("abort_diff", s8.diff, 0);
    chk("abort_borrow", s8.borrow_out, 0);
    for (int i = 0; i < 12; i++) begin
      chk("abort_res_valid", s8.res_valid, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
`ifdef SERIAL_SUB_OVF_EN
    issue8(8'h7F, 8'hFF, 0);
    wait_rv8();
    chk("ovf1_diff", s8.diff, 8'h80);
    chk("ovf1_borrow", s8.borrow_out, 1);
    chk("ovf1", s8.ovf, 1);
    @(posedge clk);
    #1;
    issue8(8'h80, 8'h01, 0);
    wait_rv8();
    chk("ovf2_diff", s8.diff, 8'h7F);
    chk("ovf2", s8.ovf, 1);
    @(posedge clk);
    #1;
    issue8(8'h05, 8'h03, 0);
    wait_rv8();
    chk("ovf3", s8.ovf, 0);
    @(posedge clk);
    #1;
`endif
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) op4(a, b, c);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
